// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch_state_e   : fetch FSM states (run, drain after halt word, halted)
//   - HaltWordDefault : default self-branch encoding (B #-1) that starts the halt drain
//   - if_id_t         : IF/ID pipeline register payload
//   - IfIdBubble      : all-zero IF/ID entry used for flushes and drain cycles
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } fetch_state_e;

    localparam logic [31:0] HaltWordDefault = 32'hEAFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IfIdBubble = '{pc: 32'h0, instr: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
//   imem_addr  : word index of the instruction being fetched (fetch unit drives)
//   imem_instr : instruction returned combinationally for imem_addr (memory drives)
// Modports: master = fetch unit side, slave = memory side.
interface if_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (
        output imem_addr,
        input  imem_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr
    );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with flush/load/hold control.
//   clk, rst : clock and asynchronous active-high reset
//   flush_i  : load a bubble (wins over load_i)
//   load_i   : capture data_i
//   data_i   : next IF/ID entry
//   data_o   : registered IF/ID entry
// With neither flush_i nor load_i the register holds.
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   load_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (flush_i) begin
            data_d = IfIdBubble;
        end else if (load_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= IfIdBubble;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register, halt-drain FSM and
// performance counters.
//   clk, rst        : clock and asynchronous active-high reset
//   freeze          : hazard stall from ID; holds PC and IF/ID
//   branch_taken    : taken branch from EXE; redirects PC and flushes IF/ID
//   branch_addr     : branch target byte address (low 2 bits ignored)
//   imem            : instruction memory bus (word index out, instruction in)
//   if_id_pc        : fetch PC + 4 of the instruction held in IF/ID
//   if_id_instr     : instruction held in IF/ID
//   if_id_valid     : IF/ID holds a real instruction
//   halted          : FSM is in the halted state
//   fetch_count     : cycles in which IF/ID loaded a valid instruction
//   flush_count     : cycles in which a branch discarded a valid IF/ID entry
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HaltWordDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_addr,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           if_id_pc,
    output logic [31:0]           if_id_instr,
    output logic                  if_id_valid,
    output logic                  halted,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  halt_pc_q, halt_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  flush_count_q, flush_count_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         id_load;
    logic         id_flush;
    if_id_t       id_next;
    if_id_t       id_cur;

    assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
    assign target   = branch_addr & ~32'h3;
    assign id_next  = '{pc: pc_plus4, instr: imem.imem_instr, valid: 1'b1};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halt_pc_d     = halt_pc_q;
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        id_load       = 1'b0;
        id_flush      = 1'b0;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    pc_d     = target;
                    id_flush = 1'b1;
                    if (id_cur.valid) begin
                        flush_count_d = flush_count_q + 32'd1;
                    end
                end else if (!freeze) begin
                    pc_d          = pc_plus4;
                    id_load       = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    // Halt word still enters IF/ID; PC then parks at halt_pc + 4.
                    if (imem.imem_instr == HALT_WORD) begin
                        state_d   = StDrain;
                        halt_pc_d = pc_q;
                    end
                end
            end
            StDrain: begin
                if (branch_taken) begin
                    id_flush = 1'b1;
                    if (id_cur.valid) begin
                        flush_count_d = flush_count_q + 32'd1;
                    end
                    // The halt instruction branching to itself confirms the halt.
                    if (target == halt_pc_q) begin
                        state_d = StHalted;
                    end else begin
                        pc_d    = target;
                        state_d = StRun;
                    end
                end else if (!freeze) begin
                    id_flush = 1'b1;
                end
            end
            StHalted: begin
                // Only reset leaves this state.
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            halt_pc_q     <= 32'h0;
            fetch_count_q <= 32'h0;
            flush_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            halt_pc_q     <= halt_pc_d;
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (id_flush),
        .load_i  (id_load),
        .data_i  (id_next),
        .data_o  (id_cur)
    );

    assign imem.imem_addr = {2'b00, pc_q[31:2]};
    assign if_id_pc       = id_cur.pc;
    assign if_id_instr    = id_cur.instr;
    assign if_id_valid    = id_cur.valid;
    assign halted         = (state_q == StHalted);
    assign fetch_count    = fetch_count_q;
    assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized freeze/branch/reset traffic checked against a behavioural model.
module tb_if_fetch_unit;

    localparam logic [31:0] HaltWord = 32'hEAFF_FFFF;
    localparam int MRun = 0, MDrain = 1, MHalted = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;

    logic [31:0] mem [256];

    logic [31:0] if_id_pc, if_id_instr, fetch_count, flush_count;
    logic        if_id_valid, halted;
    logic [31:0] w_if_id_pc, w_if_id_instr, w_fetch_count, w_flush_count;
    logic        w_if_id_valid, w_halted;

    if_fetch_unit_if imem_bus ();
    if_fetch_unit_if wrap_bus ();

    assign imem_bus.imem_instr = mem[imem_bus.imem_addr[7:0]];
    assign wrap_bus.imem_instr = mem[wrap_bus.imem_addr[7:0]];

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_bus),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .imem         (wrap_bus),
        .if_id_pc     (w_if_id_pc),
        .if_id_instr  (w_if_id_instr),
        .if_id_valid  (w_if_id_valid),
        .halted       (w_halted),
        .fetch_count  (w_fetch_count),
        .flush_count  (w_flush_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_halt_pc, m_id_pc, m_id_instr, m_fetch, m_flush;
    logic        m_id_valid;
    int          m_mode;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_halt_pc  = 32'h0;
        m_id_pc    = 32'h0;
        m_id_instr = 32'h0;
        m_id_valid = 1'b0;
        m_fetch    = 32'h0;
        m_flush    = 32'h0;
        m_mode     = MRun;
    endtask

    task automatic clear_id();
        m_id_pc    = 32'h0;
        m_id_instr = 32'h0;
        m_id_valid = 1'b0;
    endtask

    // One clock of the fetch stage, stated from the behavioural rules.
    task automatic model_step(input logic b, input logic f, input logic [31:0] addr);
        logic [31:0] tgt;
        logic [31:0] word;
        tgt  = addr & 32'hFFFF_FFFC;
        word = mem[m_pc[9:2]];
        if (m_mode == MHalted) begin
            // frozen until reset
        end else if (b) begin
            if (m_id_valid) m_flush = m_flush + 1;
            clear_id();
            if (m_mode == MDrain && tgt == m_halt_pc) begin
                m_mode = MHalted;
            end else begin
                m_pc   = tgt;
                m_mode = MRun;
            end
        end else if (f) begin
            // hold
        end else if (m_mode == MDrain) begin
            clear_id();
        end else begin
            m_id_pc    = m_pc + 4;
            m_id_instr = word;
            m_id_valid = 1'b1;
            m_fetch    = m_fetch + 1;
            if (word == HaltWord) begin
                m_mode    = MDrain;
                m_halt_pc = m_pc;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        check_eq("imem_addr", imem_bus.imem_addr, {2'b00, m_pc[31:2]});
        check_eq("if_id_pc", if_id_pc, m_id_pc);
        check_eq("if_id_instr", if_id_instr, m_id_instr);
        check_eq("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_id_valid});
        check_eq("halted", {31'h0, halted}, {31'h0, (m_mode == MHalted)});
        check_eq("fetch_count", fetch_count, m_fetch);
        check_eq("flush_count", flush_count, m_flush);
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic step(input logic b, input logic f, input logic [31:0] addr);
        branch_taken = b;
        freeze       = f;
        branch_addr  = addr;
        model_step(b, f, addr);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Asserts reset asynchronously between edges, checks it took effect at once.
    task automatic do_reset();
        branch_taken = 1'b0;
        freeze       = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_mem(input int halt_odds);
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HaltWord) mem[i] = 32'h0;
            if (halt_odds > 0 && $urandom_range(halt_odds - 1) == 0) mem[i] = HaltWord;
        end
    endtask

    initial begin
        int halted_for;
        int guard;
        logic [31:0] tgt;

        fill_mem(0);
        mem[46] = HaltWord;  // byte address 0xB8
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("rst_addr", imem_bus.imem_addr, 32'h0);

        // Free run from reset; wrap instance advances from 0xFFFFFFFC.
        step(1'b0, 1'b0, 32'h0);
        check_eq("wrap_addr", wrap_bus.imem_addr, 32'h0);
        check_eq("wrap_if_id_pc", w_if_id_pc, 32'h0);
        check_eq("wrap_valid", {31'h0, w_if_id_valid}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        check_eq("run_addr", imem_bus.imem_addr, 32'h2);
        check_eq("run_if_id_pc", if_id_pc, 32'h8);
        check_eq("run_fetch", fetch_count, 32'h2);

        // Freeze for two cycles at pc=8.
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        check_eq("frz_addr", imem_bus.imem_addr, 32'h2);
        check_eq("frz_fetch", fetch_count, 32'h2);

        // Branch wins over freeze; target low bits cleared.
        step(1'b1, 1'b1, 32'h23);
        check_eq("br_addr", imem_bus.imem_addr, 32'h8);
        check_eq("br_valid", {31'h0, if_id_valid}, 32'h0);
        check_eq("br_flush", flush_count, 32'h1);

        // Run up to the halt word at 0xB8, drain, then confirm the halt.
        guard = 0;
        while (m_pc != 32'hB8 && guard < 100) begin
            step(1'b0, 1'b0, 32'h0);
            guard++;
        end
        step(1'b0, 1'b0, 32'h0);
        check_eq("halt_instr", if_id_instr, HaltWord);
        step(1'b0, 1'b0, 32'h0);
        check_eq("drain_valid", {31'h0, if_id_valid}, 32'h0);
        step(1'b1, 1'b0, 32'hB8);
        check_eq("halted", {31'h0, halted}, 32'h1);
        check_eq("halt_addr", imem_bus.imem_addr, 32'hBC >> 2);
        step(1'b1, 1'b0, 32'h100);
        step(1'b1, 1'b1, 32'h0);
        check_eq("halt_hold_addr", imem_bus.imem_addr, 32'hBC >> 2);

        // Leave drain via a branch elsewhere.
        do_reset();
        step(1'b1, 1'b0, 32'hB8);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h40);
        check_eq("undrain_addr", imem_bus.imem_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0);
        check_eq("undrain_pc", if_id_pc, 32'h44);

        // Reset mid-drain, then reset while halted.
        step(1'b1, 1'b0, 32'hB8);
        step(1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        check_eq("post_rst_pc", if_id_pc, 32'h4);
        step(1'b1, 1'b0, 32'hB8);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'hB8);
        check_eq("halted2", {31'h0, halted}, 32'h1);
        do_reset();
        check_eq("rst_halt_addr", imem_bus.imem_addr, 32'h0);
        check_eq("rst_halted", {31'h0, halted}, 32'h0);

        // Randomized traffic.
        fill_mem(12);
        do_reset();
        halted_for = 0;
        for (int i = 0; i < 3000; i++) begin
            if (halted_for >= 4 || $urandom_range(249) == 0) begin
                do_reset();
                halted_for = 0;
            end else begin
                tgt = $urandom & 32'h3FF;
                if (m_mode == MDrain && $urandom_range(1) == 0) tgt = m_halt_pc | ($urandom & 3);
                step(($urandom_range(9) < ((m_mode == MDrain) ? 3 : 1)),
                     ($urandom_range(4) == 0), tgt);
                halted_for = (m_mode == MHalted) ? halted_for + 1 : 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
